// File: rtl/mem_ram.sv
// Single-port synchronous RAM with registered, read-first output and a one-cycle rvalid strobe.
// Optional feature: define MEM_RST_CLEAR_EN to clear every memory word asynchronously on rst.
module mem_ram #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [DATA_WIDTH-1:0] rdata_d, rdata_q;
  logic                  rvalid_d, rvalid_q;

  // Read samples the pre-write contents, so a same-edge write returns the old word.
  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    if (rd) begin
      rdata_d  = mem_q[addr];
      rvalid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

`ifdef MEM_RST_CLEAR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr) begin
      mem_q[addr] <= wdata;
    end
  end
`else
  // No reset on the array; writes are simply blocked while rst is high.
  always_ff @(posedge clk) begin
    if (!rst && wr) begin
      mem_q[addr] <= wdata;
    end
  end
`endif

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;

endmodule

// File: tb/tb_mem_ram.sv
// Self-checking bench for mem_ram: directed scenarios plus random traffic against an array model.
// Build with MEM_RST_CLEAR_EN defined to check the clearing-reset variant.
module tb_mem_ram;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 8;

  logic          clk;
  logic          rst;
  logic          rd;
  logic          wr;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          rvalid;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: array of words plus the expected output registers.
  logic [DW-1:0] mem_m [256];
  logic [DW-1:0] rdata_m;
  logic          rvalid_m;

  mem_ram #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) u_dut (
    .clk   (clk),
    .rst   (rst),
    .rd    (rd),
    .wr    (wr),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .rvalid(rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, update the model as the edge defines it, then compare outputs.
  task automatic step(input logic r, input logic w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input string tag);
    rd    = r;
    wr    = w;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1;
    if (r) rdata_m = mem_m[a];
    rvalid_m = r;
    if (w) mem_m[a] = d;
    check({tag, ".rdata"}, rdata, rdata_m);
    check({tag, ".rvalid"}, {31'd0, rvalid}, {31'd0, rvalid_m});
  endtask

  task automatic model_reset();
    rdata_m  = '0;
    rvalid_m = 1'b0;
`ifdef MEM_RST_CLEAR_EN
    for (int i = 0; i < 256; i++) mem_m[i] = '0;
`endif
  endtask

  initial begin
    rst   = 1'b1;
    rd    = 1'b0;
    wr    = 1'b0;
    addr  = '0;
    wdata = '0;
    model_reset();
    #3;
    check("reset_rdata", rdata, '0);
    check("reset_rvalid", {31'd0, rvalid}, 32'd0);
    // Requests during reset must be ignored.
    rd = 1'b1;
    wr = 1'b1;
    addr = 8'd7;
    wdata = 32'hDEADBEEF;
    @(posedge clk);
    @(negedge clk);
    check("in_reset_rdata", rdata, '0);
    check("in_reset_rvalid", {31'd0, rvalid}, 32'd0);
    rd = 1'b0;
    wr = 1'b0;
    rst = 1'b0;

    // Fill the whole array so every later read has a defined expectation.
    for (int i = 0; i < 256; i++) begin
      step(1'b0, 1'b1, 8'(i), $urandom, "fill");
    end

    // Basic write then read.
    step(1'b0, 1'b1, 8'd10, 32'hCAFEBABE, "w10");
    step(1'b1, 1'b0, 8'd10, 32'h0, "r10");
    check("r10_direct", rdata, 32'hCAFEBABE);

    // Repeated writes, back-to-back reads.
    step(1'b0, 1'b1, 8'd10, 32'hCAFEBABE, "w10a");
    step(1'b0, 1'b1, 8'd10, 32'hCAFEBABE, "w10b");
    step(1'b0, 1'b1, 8'h15, 32'h0ABCDEFE, "w15");
    step(1'b1, 1'b0, 8'h15, 32'h0, "r15");
    check("r15_direct", rdata, 32'h0ABCDEFE);
    step(1'b1, 1'b0, 8'd10, 32'h0, "r10b");
    check("r10b_direct", rdata, 32'hCAFEBABE);

    // Read-first collision.
    step(1'b0, 1'b1, 8'h20, 32'h11111111, "w20");
    step(1'b1, 1'b1, 8'h20, 32'h22222222, "rw20");
    check("rw20_direct", rdata, 32'h11111111);
    step(1'b1, 1'b0, 8'h20, 32'h0, "r20");
    check("r20_direct", rdata, 32'h22222222);

    // Address extremes and hold behaviour.
    step(1'b0, 1'b1, 8'd0, 32'hA5A50000, "w0");
    step(1'b0, 1'b1, 8'd255, 32'h0000A5A5, "w255");
    step(1'b1, 1'b0, 8'd0, 32'h0, "r0");
    check("r0_direct", rdata, 32'hA5A50000);
    step(1'b1, 1'b0, 8'd255, 32'h0, "r255");
    check("r255_direct", rdata, 32'h0000A5A5);
    step(1'b0, 1'b0, 8'd3, 32'hFFFFFFFF, "hold");
    check("hold_direct", rdata, 32'h0000A5A5);

    // Mid-cycle reset right after a read.
    step(1'b1, 1'b0, 8'd10, 32'h0, "pre_rst");
    #2 rst = 1'b1;
    #1;
    check("midrst_rdata", rdata, '0);
    check("midrst_rvalid", {31'd0, rvalid}, 32'd0);
    model_reset();
    #1 rst = 1'b0;
    step(1'b1, 1'b0, 8'd10, 32'h0, "post_rst");
`ifdef MEM_RST_CLEAR_EN
    check("post_rst_direct", rdata, 32'h0);
`else
    check("post_rst_direct", rdata, 32'hCAFEBABE);
`endif

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      logic [AW-1:0] a;
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      step(1'($urandom), 1'($urandom), a, $urandom, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/mem_ram.md
MEM_RAM -- requirements
Module: mem_ram

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 8, address width; depth = 2**ADDR_WIDTH (256 words by default).
REQ-003 Port clk, input, 1, single clock; all sampling on rising edge.
REQ-004 Port rst, input, 1; reset is asynchronous and active-high.
REQ-005 Port rd, input, 1, read request.
REQ-006 Port wr, input, 1, write request.
REQ-007 Port addr, input, ADDR_WIDTH, word address shared by read and write.
REQ-008 Port wdata, input, DATA_WIDTH, write data.
REQ-009 Port rdata, output, DATA_WIDTH, registered read data.
REQ-010 Port rvalid, output, 1, high for one cycle when rdata carries data from a read.

Function
REQ-011 Single-port synchronous RAM, 2**ADDR_WIDTH words of DATA_WIDTH bits.
REQ-012 Write: wr=1 at a rising edge stores wdata into word addr at that edge.
REQ-013 Read: rd=1 at rising edge N loads word addr into rdata at edge N; rdata and rvalid are visible after edge N, i.e. 1-cycle latency.
REQ-014 rd=0 at an edge: rdata holds its previous value and rvalid=0 after that edge.
REQ-015 rd=1 and wr=1 at the same edge: the write is performed and rdata returns the word's old contents (read-first).
REQ-016 Writes to the same address in consecutive cycles: the last write wins; repeated identical writes are harmless.
REQ-017 Back-to-back reads on consecutive edges are supported; rvalid stays high continuously while rd=1.
REQ-018 wr=0 leaves memory contents unchanged, whatever the values on addr and wdata.
REQ-019 All addresses 0 to 2**ADDR_WIDTH-1 are valid; there is no wrap-around or out-of-range condition.
REQ-020 X or Z on rd or wr counts as not asserted; no write and no read occurs.

Reset
REQ-021 rst=1 forces rdata=0 and rvalid=0 immediately, without waiting for clk.
REQ-022 While rst=1, rd and wr are ignored and no memory write occurs.
REQ-023 Without MEM_RST_CLEAR_EN, memory contents are unaffected by reset.
REQ-024 Operation resumes at the first rising edge after rst is deasserted.
REQ-025 If reset is asserted in the cycle after a read request, rdata=0 and rvalid=0 take effect and the read result is discarded.

Configuration
REQ-026 Macro MEM_RST_CLEAR_EN defined: rst=1 asynchronously clears every memory word to 0.
REQ-027 Macro MEM_RST_CLEAR_EN undefined: memory has no reset; contents are undefined (X) until written.

Verification
REQ-028 Write 32'hCAFEBABE to address 10, then read address 10 -> rdata=32'hCAFEBABE and rvalid=1 one cycle after rd.
REQ-029 Write 32'hCAFEBABE to address 10 twice, write 32'h0ABCDEFE to address 0x15, read 0x15 then 10 -> rdata=32'h0ABCDEFE, then rdata=32'hCAFEBABE.
REQ-030 Address 0x20 holds 32'h11111111; assert rd=1 and wr=1 with wdata=32'h22222222 in the same cycle -> rdata=32'h11111111; a subsequent read returns 32'h22222222.
REQ-031 Write to addresses 0 and 255, then read both -> each returns the value written; with rd=0 afterwards, rdata holds and rvalid=0.
REQ-032 Pulse rst mid-cycle after a read -> rdata=0 and rvalid=0 at once; a re-read returns the old word without MEM_RST_CLEAR_EN and 0 with it.
